add4_operand_loader: RTL
========================

// Module: add4_operand_loader
// PURPOSE
//  Serial front-end for the 4-operand adder (add4). Accepts operands one per
//  beat over a W-bit valid/ready bus and holds them in four registers that
//  drive the adder inputs a,b,c,d. Captures the adder's {ov,sum} one cycle
//  after the operands settle, then presents the registered result on a
//  valid/ready output port. Sits between the stimulus/host interface and add4.
// PARAMETERS
//  W        4   operand and sum width; must match add4
// PORTS
//  clk         in   1   system clock, all state on posedge
//  rst         in   1   asynchronous active-low reset
//  in_data     in   W   operand beat
//  in_valid    in   1   in_data valid
//  in_ready    out  1   loader can accept a beat
//  add_a       out  W   operand 0 to add4 (first beat)
//  add_b       out  W   operand 1 to add4
//  add_c       out  W   operand 2 to add4
//  add_d       out  W   operand 3 to add4 (fourth beat)
//  add_sum     in   W   add4 sum output (combinational)
//  add_ov      in   1   add4 overflow output (combinational)
//  res_sum     out  W   registered sum
//  res_ov      out  1   registered overflow
//  res_valid   out  1   result valid
//  res_ready   in   1   consumer accepts result
//  busy        out  1   high in any state other than LOAD with idx==0
// BEHAVIOUR
//  Reset (rst==0, async): state=LOAD, idx=0; add_a..add_d=0, res_sum=0,
//   res_ov=0, res_valid=0, in_ready=1, busy=0. Reset wins over all events.
//  States: LOAD, SETTLE, CAPTURE, HOLD.
//  LOAD: in_ready=1. Beat transfers when in_valid&in_ready at posedge.
//   idx 0..3 selects add_a,add_b,add_c,add_d; idx increments per transfer.
//   Transfer at idx==3 -> idx=0, state=SETTLE. No transfer -> hold idx.
//  SETTLE: in_ready=0; one idle cycle so add4 outputs settle on new operands.
//   Always -> CAPTURE next cycle.
//  CAPTURE: res_sum<=add_sum, res_ov<=add_ov, res_valid<=1, state=HOLD.
//  HOLD: res_valid=1, res_sum/res_ov stable, in_ready=0.
//   res_ready=1 at posedge -> res_valid<=0, state=LOAD.
//   res_ready=0 -> stay; result never changes or drops while pending.
//  Latency: 4th beat accepted at edge N -> res_valid=1 after edge N+2.
//  Throughput: one result per 4 beats + 2 cycles + handshake cycle; no overlap
//   of next load with pending result (in_ready=0 in SETTLE/CAPTURE/HOLD).
//  add_a..add_d keep their values after the result is consumed until
//   overwritten by the next load; a partially loaded set drives old values in
//   the unwritten slots.
//  Arithmetic is entirely in add4: {add_ov,add_sum}=(a+b+c+d) truncated to
//   W+1 bits. Loader does no arithmetic; it registers add4 outputs verbatim.
//  in_valid while in_ready=0: ignored, no side effect.
//  res_ready while res_valid=0: ignored.
//  Mid-operation reset: partial load discarded, pending result dropped,
//   all outputs to reset values within the same cycle as rst falling.
// TESTING (bench models add4 as {ov,sum}=a+b+c+d in W+1 bits)
//  1. Beats 1,2,3,4, res_ready=1 -> res_sum=10, res_ov=0, res_valid 2 cycles
//     after 4th beat, one cycle wide.
//  2. Beats 15,15,15,15 -> res_sum=12, res_ov=1; beats 8,8,8,8 -> sum=0, ov=0.
//  3. Beats 3,4,5,6 with res_ready=0 for 5 cycles -> res_valid held,
//     res_sum=2, res_ov=1 stable; in_valid pulses during hold ignored.
//  4. Gaps: in_valid low between beats 7,0,0,1 -> idx holds; result sum=8, ov=0.
//  5. rst low after 2 beats -> outputs 0, in_ready=1; then 1,1,1,1 -> sum=4.
//  6. Back-to-back: 256 random sets vs model, zero mismatches, no lost beats.

Source files
------------

// File: rtl/add4_operand_loader_if.sv
// add4_operand_loader_if: operand stream, add4 operand/result taps and result stream
interface add4_operand_loader_if #(parameter int W = 4);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_c;
  logic [W-1:0] add_d;
  logic [W-1:0] add_sum;
  logic         add_ov;
  logic [W-1:0] res_sum;
  logic         res_ov;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  modport master (
    output in_data, in_valid, add_sum, add_ov, res_ready,
    input  in_ready, add_a, add_b, add_c, add_d, res_sum, res_ov, res_valid, busy
  );
  modport slave (
    input  in_data, in_valid, add_sum, add_ov, res_ready,
    output in_ready, add_a, add_b, add_c, add_d, res_sum, res_ov, res_valid, busy
  );
endinterface

// File: rtl/add4_operand_loader.sv
// add4_operand_loader: serial operand loader and result register for add4
module add4_operand_loader #(
  parameter int W = 4
) (
  input logic                  clk,
  input logic                  rst,
  add4_operand_loader_if.slave bus
);
  typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, HOLD} state_t;
  state_t     state, state_nx;
  logic [1:0] idx;
  logic       take;
  always_comb begin
    take     = (state == LOAD) && bus.in_valid;
    state_nx = state == LOAD    ? ((take && idx == 2'd3) ? SETTLE : LOAD) :
               state == SETTLE  ? CAPTURE :
               state == CAPTURE ? HOLD :
               (bus.res_ready ? LOAD : HOLD);
  end
  assign bus.in_ready = (state == LOAD);
  assign bus.busy     = !((state == LOAD) && (idx == 2'd0));
  // idx wraps 3->0 on its own, so the fourth beat also rearms the next set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      idx           <= 2'd0;
      bus.add_a     <= {W{1'b0}};
      bus.add_b     <= {W{1'b0}};
      bus.add_c     <= {W{1'b0}};
      bus.add_d     <= {W{1'b0}};
      bus.res_sum   <= {W{1'b0}};
      bus.res_ov    <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) idx <= idx + 2'd1;
      if (take && idx == 2'd0) bus.add_a <= bus.in_data;
      if (take && idx == 2'd1) bus.add_b <= bus.in_data;
      if (take && idx == 2'd2) bus.add_c <= bus.in_data;
      if (take && idx == 2'd3) bus.add_d <= bus.in_data;
      if (state == CAPTURE) begin
        bus.res_sum   <= bus.add_sum;
        bus.res_ov    <= bus.add_ov;
        bus.res_valid <= 1'b1;
      end else if (state == HOLD && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule
